spi_slave_out: RTL and testbench
================================

SPI_SLAVE_OUT -- requirements
Module: spi_slave_out

Interface
REQ-001 Parameter BITS, default 32: word length in bits; SHALL be at least 2.
REQ-002 Parameter INVERT, default 0: when 1, miso SHALL carry the complement of the data bit.
REQ-003 clk  in  1  single system clock; all state SHALL update on its rising edge only.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cs  in  1  SPI chip select, active-low, asynchronous to clk.
REQ-006 sck  in  1  SPI serial clock, idle low, asynchronous to clk.
REQ-007 load  in  1  one-cycle strobe; writes data_in to the holding register.
REQ-008 data_in  in  BITS  next word to transmit.
REQ-009 miso  out  1  serial data out, MSB first.
REQ-010 ready  out  1  holding register empty.
REQ-011 busy  out  1  state is SHIFT.
REQ-012 done  out  1  one-cycle pulse when a word's last bit has been shifted.
REQ-013 underrun  out  1  sticky flag: a word started with no data held.

Function
REQ-014 cs and sck SHALL each pass through a 2-flop synchronizer plus 1 history flop; edges SHALL be detected from stage 2 vs history (3 clk worst-case detection latency).
REQ-015 Registers: shift[BITS-1:0], hold[BITS-1:0], hold_valid, bit index bi[$clog2(BITS)-1:0], state in {IDLE, SHIFT}.
REQ-016 load=1 SHALL set hold<=data_in and hold_valid<=1 in any state; a load while hold_valid=1 SHALL overwrite hold.
REQ-017 ready SHALL equal !hold_valid.
REQ-018 Word fetch: if hold_valid=1, shift<=hold and hold_valid<=0; else if load=1 the same cycle, shift<=data_in (bypass) and hold_valid stays 0; else shift<=0 and underrun<=1.
REQ-019 If a fetch consumes hold and load=1 in the same cycle, hold<=data_in and hold_valid SHALL remain 1.
REQ-020 IDLE -> SHIFT on detected cs falling edge: word fetch, bi<=0.
REQ-021 In SHIFT, each detected sck falling edge SHALL shift left by one (LSB filled 0) and increment bi.
REQ-022 On a falling edge with bi==BITS-1: done=1 for that cycle, bi<=0, and a word fetch SHALL replace the shift (back-to-back words within one cs assertion).
REQ-023 sck rising edges SHALL have no effect; sck edges in IDLE SHALL be ignored.
REQ-024 Detected cs high while in SHIFT SHALL return to IDLE, clear shift and bi, and assert no done; hold and hold_valid SHALL be kept.
REQ-025 If cs rises and an sck falling edge are detected in the same cycle, cs SHALL take priority.
REQ-026 miso SHALL be shift[BITS-1] XOR INVERT in SHIFT, and INVERT (logical 0 data) in IDLE; registered, no combinational path from inputs.
REQ-027 underrun SHALL clear only on load=1 or reset; a simultaneous set and clear SHALL resolve to set.
REQ-028 bi arithmetic SHALL be modulo 2^$clog2(BITS), with explicit compare to BITS-1 for non-power-of-two BITS.

Reset
REQ-029 reset=1 SHALL force: state IDLE, shift=0, hold=0, hold_valid=0, bi=0, synchronizer and history flops to cs=1 and sck=0, miso=INVERT, ready=1, busy=0, done=0, underrun=0.
REQ-030 reset SHALL take priority over load and all edges; reset asserted mid-word SHALL abort with no done pulse.
REQ-031 After reset deassertion while cs is low, no transfer SHALL start until cs is seen high and then falls again.

Verification
REQ-032 BITS=32; load 0xA5C3_0F01, drop cs, 32 sck pulses (>=8 clk per phase) -> miso bits 1,0,1,0,0,1,0,1,... MSB first; done pulses once after the 32nd sck fall; ready=1 after fetch.
REQ-033 Hold 0x1111_1111 then load 0x2222_2222 mid-word; 64 sck pulses in one cs -> 0x1111_1111 then 0x2222_2222 with no gap; done twice; underrun=0.
REQ-034 No load, drop cs -> miso=0 for 32 bits, underrun=1 until the next load, done after the 32nd bit.
REQ-035 cs rises after 10 sck falls -> busy=0 within 3 clk, no done, miso=0; held word still sent intact on the next cs.
REQ-036 load coincident with the detected cs fall and hold empty -> data_in sent (bypass), ready stays 1.
REQ-037 INVERT=1, word 0x0000_0001 -> miso high for bits 31..1, low for bit 0, high in IDLE; reset mid-word -> all outputs at REQ-029 values next cycle.

Source files
------------

// File: rtl/spi_slave_out.sv
// SPI slave transmitter: double-buffered word output on miso,
// MSB first, driven from synchronized cs/sck.
module spi_slave_out #(
  parameter int BITS   = 32,
  parameter bit INVERT = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cs,
  input  logic            sck,
  input  logic            load,
  input  logic [BITS-1:0] data_in,
  output logic            miso,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            underrun
);

  localparam int BW = $clog2(BITS);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic [BITS-1:0] hold_q, hold_d;
  logic            hv_q, hv_d;
  logic [BW-1:0]   bi_q, bi_d;
  logic            done_q, done_d;
  logic            und_q, und_d;
  logic            miso_q, miso_d;

  logic            cs_s1_q, cs_s2_q, cs_h_q;
  logic            sck_s1_q, sck_s2_q, sck_h_q;
  logic [1:0]      vld_q;
  logic            arm_q, arm_d;

  logic            cs_fall;
  logic            sck_fall;
  logic            fetch;
  logic            und_set;

  assign cs_fall  = arm_q & cs_h_q & ~cs_s2_q;
  assign sck_fall = sck_h_q & ~sck_s2_q;

  // Arm only once stage 2 holds a real high sample of cs,
  // so a cs held low through reset cannot start a word.
  assign arm_d = arm_q | (vld_q[1] & cs_s2_q);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    hv_d    = hv_q;
    bi_d    = bi_q;
    done_d  = 1'b0;
    und_d   = und_q;
    fetch   = 1'b0;
    und_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          bi_d    = '0;
          fetch   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_s2_q) begin
          state_d = IDLE;
          shift_d = '0;
          bi_d    = '0;
        end else if (sck_fall) begin
          if (bi_q == BW'(BITS - 1)) begin
            done_d = 1'b1;
            bi_d   = '0;
            fetch  = 1'b1;
          end else begin
            shift_d = {shift_q[BITS-2:0], 1'b0};
            bi_d    = bi_q + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fetch) begin
      if (hv_q) begin
        shift_d = hold_q;
        hv_d    = 1'b0;
      end else if (load) begin
        shift_d = data_in;
      end else begin
        shift_d = '0;
        und_set = 1'b1;
      end
    end

    if (load) begin
      hold_d = data_in;
      if (!(fetch && !hv_q)) hv_d = 1'b1;
    end

    if (und_set)   und_d = 1'b1;
    else if (load) und_d = 1'b0;

    miso_d = (state_d == SHIFT) ? (shift_d[BITS-1] ^ INVERT) : INVERT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      hold_q   <= '0;
      hv_q     <= 1'b0;
      bi_q     <= '0;
      done_q   <= 1'b0;
      und_q    <= 1'b0;
      miso_q   <= INVERT;
      cs_s1_q  <= 1'b1;
      cs_s2_q  <= 1'b1;
      cs_h_q   <= 1'b1;
      sck_s1_q <= 1'b0;
      sck_s2_q <= 1'b0;
      sck_h_q  <= 1'b0;
      vld_q    <= '0;
      arm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      hold_q   <= hold_d;
      hv_q     <= hv_d;
      bi_q     <= bi_d;
      done_q   <= done_d;
      und_q    <= und_d;
      miso_q   <= miso_d;
      cs_s1_q  <= cs;
      cs_s2_q  <= cs_s1_q;
      cs_h_q   <= cs_s2_q;
      sck_s1_q <= sck;
      sck_s2_q <= sck_s1_q;
      sck_h_q  <= sck_s2_q;
      vld_q    <= {vld_q[0], 1'b1};
      arm_q    <= arm_d;
    end
  end

  assign miso     = miso_q;
  assign ready    = ~hv_q;
  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign underrun = und_q;

endmodule

// File: tb/tb_spi_slave_out.sv
// Directed bench for spi_slave_out: table of single-word transfers
// plus sequences for back-to-back, abort, bypass, reset and INVERT.
module tb_spi_slave_out;

  localparam int BITS = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            cs = 1'b1;
  logic            sck = 1'b0;
  logic            load = 1'b0;
  logic [BITS-1:0] data_in = '0;
  logic            miso0, ready0, busy0, done0, und0;
  logic            miso1, ready1, busy1, done1, und1;

  int n_vec = 0;
  int n_bad = 0;
  int dcnt0 = 0;

  always #5 clk = ~clk;

  spi_slave_out #(.BITS(BITS), .INVERT(1'b0)) u0 (
    .clk(clk), .reset(reset), .cs(cs), .sck(sck),
    .load(load), .data_in(data_in), .miso(miso0),
    .ready(ready0), .busy(busy0), .done(done0),
    .underrun(und0)
  );

  spi_slave_out #(.BITS(BITS), .INVERT(1'b1)) u1 (
    .clk(clk), .reset(reset), .cs(cs), .sck(sck),
    .load(load), .data_in(data_in), .miso(miso1),
    .ready(ready1), .busy(busy1), .done(done1),
    .underrun(und1)
  );

  always @(posedge clk) if (done0) dcnt0 <= dcnt0 + 1;

  typedef struct {
    logic [31:0] data;
    bit          ld;
    logic [31:0] exp;
    bit          und;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(input logic [31:0] d);
    load = 1'b1;
    data_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic xfer(input int n, input int ld_at,
                      input logic [31:0] ld_d,
                      output logic [63:0] g0,
                      output logic [63:0] g1,
                      output logic und_last);
    g0 = '0;
    g1 = '0;
    und_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      clks(8);
      g0 = {g0[62:0], miso0};
      g1 = {g1[62:0], miso1};
      und_last = und0;
      if (i == ld_at) pulse_load(ld_d);
      sck = 1'b1;
      clks(8);
      sck = 1'b0;
    end
    clks(8);
  endtask

  initial begin
    logic [63:0] g0, g1;
    logic        ul;
    int          d0;

    tbl[0] = '{32'hA5C3_0F01, 1'b1, 32'hA5C3_0F01, 1'b0};
    tbl[1] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b1};
    tbl[2] = '{32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0};
    tbl[3] = '{32'h8000_0001, 1'b1, 32'h8000_0001, 1'b0};

    clks(3);
    chk("rst_miso0", 64'(miso0), 64'd0);
    chk("rst_miso1", 64'(miso1), 64'd1);
    chk("rst_ready", 64'(ready0), 64'd1);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_und", 64'(und0), 64'd0);
    reset = 1'b0;
    clks(4);

    for (int v = 0; v < 4; v++) begin
      if (tbl[v].ld) pulse_load(tbl[v].data);
      d0 = dcnt0;
      cs = 1'b0;
      xfer(32, -1, '0, g0, g1, ul);
      chk($sformatf("v%0d_word", v), g0[31:0], 64'(tbl[v].exp));
      chk($sformatf("v%0d_und", v), 64'(ul), 64'(tbl[v].und));
      chk($sformatf("v%0d_done", v), 64'(dcnt0 - d0), 64'd1);
      chk($sformatf("v%0d_ready", v), 64'(ready0), 64'd1);
      cs = 1'b1;
      clks(8);
      chk($sformatf("v%0d_idle", v), {busy0, miso0}, 64'd0);
    end

    // Back-to-back words with a mid-word reload.
    pulse_load(32'h1111_1111);
    d0 = dcnt0;
    cs = 1'b0;
    xfer(64, 5, 32'h2222_2222, g0, g1, ul);
    chk("b2b_word", g0, 64'h1111_1111_2222_2222);
    chk("b2b_done", 64'(dcnt0 - d0), 64'd2);
    chk("b2b_und", 64'(ul), 64'd0);
    cs = 1'b1;
    clks(8);

    // Abort after 10 bits; the held word survives.
    pulse_load(32'h1234_5678);
    d0 = dcnt0;
    cs = 1'b0;
    xfer(10, 3, 32'hCAFE_F00D, g0, g1, ul);
    chk("abort_part", g0[9:0], 64'(10'b0001001000));
    cs = 1'b1;
    clks(3);
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_miso", 64'(miso0), 64'd0);
    chk("abort_ready", 64'(ready0), 64'd0);
    chk("abort_done", 64'(dcnt0 - d0), 64'd0);
    clks(5);
    cs = 1'b0;
    xfer(32, -1, '0, g0, g1, ul);
    chk("abort_next", g0[31:0], 64'hCAFE_F00D);
    chk("abort_ndone", 64'(dcnt0 - d0), 64'd1);
    cs = 1'b1;
    clks(8);

    // Load coincident with detected cs fall, hold empty.
    chk("byp_pre_ready", 64'(ready0), 64'd1);
    cs = 1'b0;
    clks(2);
    load = 1'b1;
    data_in = 32'h5A5A_3C3C;
    @(negedge clk);
    load = 1'b0;
    chk("byp_ready", 64'(ready0), 64'd1);
    chk("byp_busy", 64'(busy0), 64'd1);
    xfer(32, -1, '0, g0, g1, ul);
    chk("byp_word", g0[31:0], 64'h5A5A_3C3C);
    cs = 1'b1;
    clks(8);

    // Reset released with cs low must not start a word.
    cs = 1'b0;
    reset = 1'b1;
    clks(2);
    reset = 1'b0;
    clks(20);
    chk("rlow_busy", 64'(busy0), 64'd0);
    cs = 1'b1;
    clks(8);
    pulse_load(32'h0F0F_00FF);
    cs = 1'b0;
    xfer(32, -1, '0, g0, g1, ul);
    chk("rlow_word", g0[31:0], 64'h0F0F_00FF);
    cs = 1'b1;
    clks(8);

    // Inverted output and reset mid-word.
    chk("inv_idle", 64'(miso1), 64'd1);
    pulse_load(32'h0000_0001);
    cs = 1'b0;
    xfer(32, -1, '0, g0, g1, ul);
    chk("inv_word", g1[31:0], 64'hFFFF_FFFE);
    cs = 1'b1;
    clks(8);
    pulse_load(32'hFFFF_0000);
    d0 = dcnt0;
    cs = 1'b0;
    xfer(10, -1, '0, g0, g1, ul);
    chk("inv_mid_busy", 64'(busy1), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("inv_rst", {miso1, ready1, busy1, done1, und1},
        64'(5'b11000));
    chk("inv_rst_u0", {miso0, ready0, busy0}, 64'(3'b010));
    reset = 1'b0;
    cs = 1'b1;
    clks(8);
    chk("inv_rst_done", 64'(dcnt0 - d0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
